// File: rtl/pe_array_ctrl.sv
// Tile-job sequencer for a weight-stationary systolic PE array: weight load, activation stream, result tracking.
// Latency: busy one cycle after start; result k at act_rd_en(k) + pipe_latency; done one cycle after the last result.
// Backpressure: only w_valid stalls the weight load; activation issue and drain run freely once started.
module pe_array_ctrl #(
  parameter int w_tile_row_size    = 6,
  parameter int w_tile_column_size = 6,
  parameter int pipe_latency       = w_tile_row_size + w_tile_column_size,
  parameter int cnt_width          = 16,
  localparam int RIW = (w_tile_row_size > 1) ? $clog2(w_tile_row_size) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 reuse_weights,
  input  logic [cnt_width-1:0] num_vectors,
  output logic                 busy,
  output logic                 done,
  output logic                 w_req,
  input  logic                 w_valid,
  output logic [RIW-1:0]       w_row_idx,
  output logic                 w_en,
  output logic                 w_compute,
  output logic                 act_rd_en,
  output logic [cnt_width-1:0] act_idx,
  output logic                 sum_valid,
  output logic [cnt_width-1:0] sum_idx
);

  localparam int                 L        = pipe_latency;
  localparam logic [RIW-1:0]     ROW_LAST = RIW'(w_tile_row_size - 1);
  localparam logic [cnt_width-1:0] ONE    = cnt_width'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [RIW-1:0]       row_q, row_d;
  logic [cnt_width-1:0] num_q, num_d;
  logic [cnt_width-1:0] act_q, act_d;
  logic [cnt_width-1:0] sum_q, sum_d;
  logic [L-1:0]         vld_q, vld_d;

  assign w_row_idx = row_q;
  assign act_idx   = act_q;
  assign sum_idx   = sum_q;
  assign sum_valid = vld_q[L-1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Counters and the in-flight result tracker; reset drops every in-flight vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      num_q <= '0;
      act_q <= '0;
      sum_q <= '0;
      vld_q <= '0;
    end else begin
      row_q <= row_d;
      num_q <= num_d;
      act_q <= act_d;
      sum_q <= sum_d;
      vld_q <= vld_d;
    end
  end

  // Next-state, counter updates and per-state array/buffer strobes.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    num_d     = num_q;
    act_d     = act_q;
    sum_d     = sum_q;
    busy      = 1'b0;
    done      = 1'b0;
    w_req     = 1'b0;
    w_en      = 1'b0;
    w_compute = 1'b0;
    act_rd_en = 1'b0;

    // Results are counted as they leave the array, independent of issue.
    if (sum_valid) sum_d = sum_q + ONE;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d = num_vectors;
          row_d = '0;
          act_d = '0;
          sum_d = '0;
          if (!reuse_weights)          state_d = S_LOAD;
          else if (num_vectors == '0)  state_d = S_DONE;
          else                         state_d = S_COMPUTE;
        end
      end
      S_LOAD: begin
        busy  = 1'b1;
        w_req = 1'b1;
        w_en  = w_valid;
        if (w_valid) begin
          // Counter stops on the last row so it never wraps inside a job.
          if (row_q == ROW_LAST) state_d = (num_q == '0) ? S_DONE : S_COMPUTE;
          else                   row_d   = row_q + 1'b1;
        end
      end
      S_COMPUTE: begin
        busy      = 1'b1;
        w_compute = 1'b1;
        act_rd_en = 1'b1;
        if (act_q == num_q - ONE) state_d = S_DRAIN;
        else                      act_d   = act_q + ONE;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        w_compute = 1'b1;
        if (sum_valid && (sum_q == num_q - ONE)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    vld_d = (vld_q << 1) | L'(act_rd_en);
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
module tb_pe_array_ctrl;

  localparam int CW  = 16;
  localparam int RIW = 3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          reuse_weights;
  logic [CW-1:0] num_vectors;
  logic          busy;
  logic          done;
  logic          w_req;
  logic          w_valid;
  logic [RIW-1:0] w_row_idx;
  logic          w_en;
  logic          w_compute;
  logic          act_rd_en;
  logic [CW-1:0] act_idx;
  logic          sum_valid;
  logic [CW-1:0] sum_idx;

  pe_array_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reuse_weights(reuse_weights),
    .num_vectors(num_vectors), .busy(busy), .done(done), .w_req(w_req),
    .w_valid(w_valid), .w_row_idx(w_row_idx), .w_en(w_en), .w_compute(w_compute),
    .act_rd_en(act_rd_en), .act_idx(act_idx), .sum_valid(sum_valid), .sum_idx(sum_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic        reuse;
    int          n;
    logic [63:0] stall;
    int          pulse;
    int          wreq, wen, act_first, act_cnt, sum_first, sum_cnt, done_c, busy;
  } vec_t;

  typedef struct {
    int wreq, wen, act_first, act_cnt, sum_first, sum_cnt, done_c, busy;
    int ovl, row_err, act_err, sum_err;
  } meas_t;

  // Run one job with start in cycle 0; cycle c is sampled mid-cycle after inputs settle.
  task automatic run_job(input logic reuse, input int n, input logic [63:0] stall,
                         input int pulse, output meas_t m);
    m = '{0, 0, -1, 0, -1, 0, -1, 0, 0, 0, 0, 0};
    @(negedge clk);
    start = 1'b1; reuse_weights = reuse; num_vectors = CW'(n); w_valid = !stall[0];
    for (int cyc = 1; cyc < 300; cyc++) begin
      @(negedge clk);
      start   = (cyc == pulse);
      w_valid = (cyc < 64) ? !stall[cyc] : 1'b1;
      #1;
      if (w_req) m.wreq++;
      if (w_en) begin
        if (int'(w_row_idx) != m.wen) m.row_err++;
        m.wen++;
      end
      if (act_rd_en) begin
        if (m.act_first < 0) m.act_first = cyc;
        if (int'(act_idx) != m.act_cnt) m.act_err++;
        m.act_cnt++;
      end
      if (sum_valid) begin
        if (m.sum_first < 0) m.sum_first = cyc;
        if (int'(sum_idx) != m.sum_cnt) m.sum_err++;
        m.sum_cnt++;
      end
      if (busy) m.busy++;
      if (w_en && w_compute) m.ovl++;
      if (done) begin
        m.done_c = cyc;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0; w_valid = 1'b1;
  endtask

  vec_t  vt[6];
  meas_t m;
  int    stray;

  initial begin
    // reuse, N, stall mask, start pulse, w_req, w_en, act first, act count, sum first, sum count, done, busy
    vt[0] = '{1'b0, 3,  64'h0,  -1, 6, 6, 7,  3,  19, 3,  22, 21};
    vt[1] = '{1'b0, 3,  64'h14, -1, 8, 6, 9,  3,  21, 3,  24, 23};
    vt[2] = '{1'b1, 2,  64'h0,  -1, 0, 0, 1,  2,  13, 2,  15, 14};
    vt[3] = '{1'b0, 0,  64'h0,  -1, 6, 6, -1, 0,  -1, 0,  7,  6};
    vt[4] = '{1'b1, 0,  64'h0,  -1, 0, 0, -1, 0,  -1, 0,  1,  0};
    vt[5] = '{1'b0, 20, 64'h0,  10, 6, 6, 7,  20, 19, 20, 39, 38};

    rst_n = 1'b0; start = 1'b0; reuse_weights = 1'b0; num_vectors = '0; w_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_outputs", int'({busy, done, w_req, w_en, w_compute, act_rd_en, sum_valid}), 0);
    check("rst_indices", int'(w_row_idx) + int'(act_idx) + int'(sum_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_job(vt[i].reuse, vt[i].n, vt[i].stall, vt[i].pulse, m);
      check($sformatf("v%0d_wreq", i),      m.wreq,      vt[i].wreq);
      check($sformatf("v%0d_wen", i),       m.wen,       vt[i].wen);
      check($sformatf("v%0d_act_first", i), m.act_first, vt[i].act_first);
      check($sformatf("v%0d_act_cnt", i),   m.act_cnt,   vt[i].act_cnt);
      check($sformatf("v%0d_sum_first", i), m.sum_first, vt[i].sum_first);
      check($sformatf("v%0d_sum_cnt", i),   m.sum_cnt,   vt[i].sum_cnt);
      check($sformatf("v%0d_done", i),      m.done_c,    vt[i].done_c);
      check($sformatf("v%0d_busy", i),      m.busy,      vt[i].busy);
      check($sformatf("v%0d_idx_errs", i),  m.row_err + m.act_err + m.sum_err, 0);
      check($sformatf("v%0d_wen_wcomp", i), m.ovl,       0);
      #1;
      check($sformatf("v%0d_idle_after", i), int'({busy, done}), 0);
      repeat (2) @(negedge clk);
    end

    // Mid-job reset: N=20 job, reset asserted in cycle 15 while vectors are in flight.
    @(negedge clk);
    start = 1'b1; reuse_weights = 1'b0; num_vectors = CW'(20); w_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    check("pre_rst_busy", int'(busy & act_rd_en), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", int'({busy, done, w_req, w_en, w_compute, act_rd_en, sum_valid}), 0);
    check("midrst_indices", int'(w_row_idx) + int'(act_idx) + int'(sum_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (sum_valid || busy || done) stray++;
    end
    check("postrst_quiet", stray, 0);

    run_job(1'b0, 3, 64'h0, -1, m);
    check("rerun_act_first", m.act_first, 7);
    check("rerun_sum_first", m.sum_first, 19);
    check("rerun_sum_cnt",   m.sum_cnt,   3);
    check("rerun_done",      m.done_c,    22);
    check("rerun_idx_errs",  m.row_err + m.act_err + m.sum_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
